adder_arbiter: RTL and testbench



---
 rtl/adder_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/adder_arbiter.sv | 109 ++++++++++
 tb/tb_adder_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the arbitrated add/sub datapath: operand width and op codes.
package adder_pkg;

  localparam int XLEN = 64;
  localparam int OPW  = 4;

  localparam logic [OPW-1:0] OP_ADD  = 4'd0;
  localparam logic [OPW-1:0] OP_SUB  = 4'd1;
  localparam logic [OPW-1:0] OP_ADDW = 4'd2;
  localparam logic [OPW-1:0] OP_SUBW = 4'd3;
  localparam logic [OPW-1:0] OP_ADDA = 4'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or above ptr, wrapping at NREQ-1.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grantIdx,
  output logic            o_anyGrant
);

  always_comb begin
    int j;
    o_grant    = '0;
    o_grantIdx = '0;
    o_anyGrant = 1'b0;
    j          = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!o_anyGrant && i_req[j]) begin
        o_anyGrant    = 1'b1;
        o_grant[j]    = 1'b1;
        o_grantIdx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one add/sub datapath between NREQ requesters with round-robin grant
// and a single registered response stage (1-cycle latency, full backpressure).
module adder_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = adder_pkg::XLEN,
  parameter int OPW  = adder_pkg::OPW,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_src1,
  input  logic [NREQ*XLEN-1:0] req_src2,
  input  logic [NREQ*OPW-1:0]  req_op,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]      rsp_result,
  output logic [IDW-1:0]       rsp_id
);

  import adder_pkg::*;

  logic            r_stageValid;
  logic [IDW-1:0]  r_stageId;
  logic [XLEN-1:0] r_stageResult;
  logic [IDW-1:0]  r_rrPtr;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_grantIdx;
  logic            w_anyGrant;
  logic            w_drain;
  logic            w_accept;
  logic            w_handshake;
  logic [IDW-1:0]  w_nextPtr;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;
  logic [OPW-1:0]  w_op;
  logic            w_isSub;
  logic [XLEN-1:0] w_opB;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_result;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req      (req_valid),
    .i_ptr      (r_rrPtr),
    .o_grant    (w_grant),
    .o_grantIdx (w_grantIdx),
    .o_anyGrant (w_anyGrant)
  );

  // A full stage can still accept when its owner drains it in the same cycle.
  assign w_drain     = r_stageValid & rsp_ready[r_stageId];
  assign w_accept    = ~r_stageValid | w_drain;
  assign w_handshake = w_anyGrant & w_accept;
  assign req_ready   = w_grant & {NREQ{w_accept}};
  assign w_nextPtr   = (int'(w_grantIdx) == NREQ - 1) ? '0 : w_grantIdx + 1'b1;

  always_comb begin
    w_src1 = '0;
    w_src2 = '0;
    w_op   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grantIdx == IDW'(i)) begin
        w_src1 = req_src1[i*XLEN +: XLEN];
        w_src2 = req_src2[i*XLEN +: XLEN];
        w_op   = req_op[i*OPW +: OPW];
      end
    end
  end

  // Subtraction reuses the adder as s1 + ~s2 + 1; unknown ops fall through to ADD.
  assign w_isSub = (w_op == OP_SUB) || (w_op == OP_SUBW);
  assign w_opB   = w_isSub ? ~w_src2 : w_src2;
  assign w_sum   = w_src1 + w_opB + {{(XLEN-1){1'b0}}, w_isSub};

  always_comb begin
    w_result = w_sum;
    if ((w_op == OP_ADDW) || (w_op == OP_SUBW))
      w_result = {{(XLEN-32){w_sum[31]}}, w_sum[31:0]};
    else if (w_op == OP_ADDA)
      w_result = w_sum & ~{{(XLEN-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stageValid  <= 1'b0;
      r_stageId     <= '0;
      r_stageResult <= '0;
      r_rrPtr       <= '0;
    end else if (w_handshake) begin
      r_stageValid  <= 1'b1;
      r_stageId     <= w_grantIdx;
      r_stageResult <= w_result;
      r_rrPtr       <= w_nextPtr;
    end else if (w_drain) begin
      r_stageValid  <= 1'b0;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (r_stageValid) rsp_valid[r_stageId] = 1'b1;
  end

  assign rsp_result = r_stageResult;
  assign rsp_id     = r_stageId;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: op results, round-robin order, backpressure and reset.
module tb_adder_arbiter;
  import adder_pkg::*;

  localparam int NREQ = 3;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*64-1:0]   req_src1;
  logic [NREQ*64-1:0]   req_src2;
  logic [NREQ*4-1:0]    req_op;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [63:0]          rsp_result;
  logic [IDW-1:0]       rsp_id;

  int total = 0;
  int bad   = 0;

  adder_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [3:0] op,
                               input logic [63:0] a, input logic [63:0] b);
    req_src1[idx*64 +: 64] = a;
    req_src2[idx*64 +: 64] = b;
    req_op[idx*4 +: 4]     = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one lone request, checks its response the next cycle and that the stage then empties.
  task automatic runSingle(input string tag, input int idx, input logic [3:0] op,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    logic [2:0] oh;
    oh = 3'b001 << idx;
    applyStimulus(idx, op, a, b);
    req_valid = oh;
    #1;
    checkOutput({tag, " ready"}, 64'(req_ready), 64'(oh));
    tick();
    req_valid = '0;
    checkOutput({tag, " valid"}, 64'(rsp_valid), 64'(oh));
    checkOutput({tag, " id"}, 64'(rsp_id), 64'(idx));
    checkOutput({tag, " result"}, rsp_result, exp);
    tick();
    checkOutput({tag, " empty"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] fairExp [3];
    logic [2:0]  oh;
    rst_n     = 1'b0;
    req_valid = '0;
    req_src1  = '0;
    req_src2  = '0;
    req_op    = '0;
    rsp_ready = '1;
    #12;
    checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset rsp_result", rsp_result, 64'd0);
    checkOutput("reset rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("reset req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    runSingle("add", 0, OP_ADD, 64'd5, 64'd7, 64'd12);
    runSingle("subw", 1, OP_SUBW, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    runSingle("addw", 0, OP_ADDW, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
    runSingle("sub", 2, OP_SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    runSingle("addwrap", 0, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    runSingle("addwtrunc", 1, OP_ADDW, 64'h1_0000_0005, 64'd3, 64'd8);
    runSingle("opF", 1, 4'hF, 64'd3, 64'd4, 64'd7);
    runSingle("adda", 2, OP_ADDA, 64'h1001, 64'h4, 64'h1004);

    // Pointer is back at 0: all three requesting must be served 0,1,2,0,1,2.
    applyStimulus(0, OP_ADD, 64'd1, 64'd1);
    applyStimulus(1, OP_SUB, 64'd10, 64'd3);
    applyStimulus(2, OP_ADDA, 64'h11, 64'h0);
    fairExp[0] = 64'd2;
    fairExp[1] = 64'd7;
    fairExp[2] = 64'h10;
    req_valid = 3'b111;
    #1;
    for (int c = 0; c < 6; c++) begin
      oh = 3'b001 << (c % 3);
      checkOutput($sformatf("fair ready %0d", c), 64'(req_ready), 64'(oh));
      tick();
      checkOutput($sformatf("fair valid %0d", c), 64'(rsp_valid), 64'(oh));
      checkOutput($sformatf("fair id %0d", c), 64'(rsp_id), 64'(c % 3));
      checkOutput($sformatf("fair result %0d", c), rsp_result, fairExp[c % 3]);
    end
    req_valid = '0;
    tick();
    checkOutput("fair empty", 64'(rsp_valid), 64'd0);

    // Backpressure on requester 1's response; pointer should sit at 2.
    rsp_ready = 3'b101;
    req_valid = 3'b010;
    tick();
    req_valid = 3'b101;
    applyStimulus(1, OP_ADD, 64'd100, 64'd100);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("bp ready %0d", c), 64'(req_ready), 64'd0);
      checkOutput($sformatf("bp valid %0d", c), 64'(rsp_valid), 64'(3'b010));
      checkOutput($sformatf("bp id %0d", c), 64'(rsp_id), 64'd1);
      checkOutput($sformatf("bp result %0d", c), rsp_result, 64'd7);
      tick();
    end
    rsp_ready = 3'b111;
    #1;
    checkOutput("bp release ready", 64'(req_ready), 64'(3'b100));
    tick();
    req_valid = '0;
    checkOutput("bp next valid", 64'(rsp_valid), 64'(3'b100));
    checkOutput("bp next id", 64'(rsp_id), 64'd2);
    checkOutput("bp next result", rsp_result, 64'h10);
    tick();

    // Reset while a response is held; pointer left at 1 must return to 0.
    rsp_ready = 3'b000;
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    checkOutput("rst pre valid", 64'(rsp_valid), 64'(3'b001));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst async valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst async result", rsp_result, 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 3'b111;
    req_valid = 3'b111;
    #1;
    checkOutput("rst first ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;
    checkOutput("rst first valid", 64'(rsp_valid), 64'(3'b001));
    checkOutput("rst first id", 64'(rsp_id), 64'd0);
    checkOutput("rst first result", rsp_result, 64'd2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
